// File: rtl/smi_pkg.sv
// smi_pkg: definitions shared by the SMI responder and the SMI master.
//   smi_state_t   - frame decoder states
//   OP_READ/WRITE - clause-22 opcodes, ST_CODE - start-of-frame pattern
//   SMI_REG_RESET - power-on contents of the 32 x 16-bit register file
package smi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } smi_state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST_CODE  = 2'b01;

  // Element [n] is register n.
  localparam logic [31:0][15:0] SMI_REG_RESET = {
    {28{16'h0000}}, 16'h1550, 16'h0022, 16'h7849, 16'h1140
  };

endpackage

// File: rtl/smi_edge_sync.sv
// smi_edge_sync: brings mdc/mdio into the clk domain.
//   clk, rst   - system clock, async active-high reset
//   mdc        - raw management clock
//   mdio_in    - raw management data
//   mdc_rise   - 1-cycle pulse on a synchronised mdc rising edge
//   mdc_fall   - 1-cycle pulse on a synchronised mdc falling edge
//   mdio_sync  - mdio after two flops, aligned with the mdc pulses
module smi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio_in,
  output logic mdc_rise,
  output logic mdc_fall,
  output logic mdio_sync
);

  logic mdc_s1_q, mdc_s1_d;
  logic mdc_s2_q, mdc_s2_d;
  logic mdc_prev_q, mdc_prev_d;
  logic mdio_s1_q, mdio_s1_d;
  logic mdio_s2_q, mdio_s2_d;

  always_comb begin
    mdc_s1_d   = mdc;
    mdc_s2_d   = mdc_s1_q;
    mdc_prev_d = mdc_s2_q;
    mdio_s1_d  = mdio_in;
    mdio_s2_d  = mdio_s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_s1_q   <= 1'b0;
      mdc_s2_q   <= 1'b0;
      mdc_prev_q <= 1'b0;
      mdio_s1_q  <= 1'b0;
      mdio_s2_q  <= 1'b0;
    end else begin
      mdc_s1_q   <= mdc_s1_d;
      mdc_s2_q   <= mdc_s2_d;
      mdc_prev_q <= mdc_prev_d;
      mdio_s1_q  <= mdio_s1_d;
      mdio_s2_q  <= mdio_s2_d;
    end
  end

  assign mdc_rise  = mdc_s2_q & ~mdc_prev_q;
  assign mdc_fall  = ~mdc_s2_q & mdc_prev_q;
  assign mdio_sync = mdio_s2_q;

endmodule

// File: rtl/smi_responder.sv
// smi_responder: PHY-side clause-22 SMI/MDIO target backed by a 32 x 16-bit
// register file.
//   clk_100mhz, rst          - system clock, async active-high reset
//   mdc, mdio                - management clock / bidirectional data
//   loc_we/addr/wdata/rdata  - fabric-side register port (rdata 1-cycle latency)
//   smi_wr_valid/addr/data   - pulse when an SMI write commits
//   smi_rd_valid/addr        - pulse when an SMI read latches its register
//   frame_err                - pulse on bad ST, OP or write TA
// Build option: SMI_RESPONDER_PREAMBLE_SUPPRESS_EN lets a frame that follows
// a completed valid frame start after a single preamble one.
module smi_responder
  import smi_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [31:0] RO_MASK  = 32'h0000_0006,
  parameter int unsigned PRE_LEN  = 32
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        mdc,
  inout  wire         mdio,
  input  logic        loc_we,
  input  logic [4:0]  loc_addr,
  input  logic [15:0] loc_wdata,
  output logic [15:0] loc_rdata,
  output logic        smi_wr_valid,
  output logic [4:0]  smi_wr_addr,
  output logic [15:0] smi_wr_data,
  output logic        smi_rd_valid,
  output logic [4:0]  smi_rd_addr,
  output logic        frame_err
);

  localparam logic [5:0] PRE_MIN = 6'(PRE_LEN);

  logic mdc_rise, mdc_fall, mdio_s;

  smi_edge_sync u_sync (
    .clk       (clk_100mhz),
    .rst       (rst),
    .mdc       (mdc),
    .mdio_in   (mdio),
    .mdc_rise  (mdc_rise),
    .mdc_fall  (mdc_fall),
    .mdio_sync (mdio_s)
  );

  smi_state_t        state_q, state_d;
  logic [5:0]        pre_cnt_q, pre_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              is_read_q, is_read_d;
  logic [3:0]        addr_sh_q, addr_sh_d;
  logic [15:0]       shift_q, shift_d;
  logic              mdio_oe_q, mdio_oe_d;
  logic              mdio_out_q, mdio_out_d;
  logic [31:0][15:0] regs_q, regs_d;
  logic [15:0]       loc_rdata_q, loc_rdata_d;
  logic              wr_valid_q, wr_valid_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic              frame_err_q, frame_err_d;
`ifdef SMI_RESPONDER_PREAMBLE_SUPPRESS_EN
  logic              sup_q, sup_d;
`endif

  logic        smi_we, abort, frame_end, pre_ok;
  logic [4:0]  smi_wa;
  logic [15:0] smi_wd;

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    is_read_d   = is_read_q;
    addr_sh_d   = addr_sh_q;
    shift_d     = shift_q;
    mdio_oe_d   = mdio_oe_q;
    mdio_out_d  = mdio_out_q;
    regs_d      = regs_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_valid_d  = 1'b0;
    rd_addr_d   = rd_addr_q;
    frame_err_d = 1'b0;
    smi_we      = 1'b0;
    smi_wa      = '0;
    smi_wd      = '0;
    abort       = 1'b0;
    frame_end   = 1'b0;
`ifdef SMI_RESPONDER_PREAMBLE_SUPPRESS_EN
    sup_d  = sup_q;
    pre_ok = (pre_cnt_q >= PRE_MIN) || (sup_q && (pre_cnt_q != '0));
`else
    pre_ok = (pre_cnt_q >= PRE_MIN);
`endif

    if (mdc_rise) begin
      unique case (state_q)
        S_IDLE: begin
          if (mdio_s) begin
            if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + 6'd1;
          end else begin
            // This 0 is the first ST bit when enough preamble preceded it.
            pre_cnt_d = '0;
            if (pre_ok) state_d = S_ST;
          end
        end
        S_ST: begin
          if (mdio_s == ST_CODE[0]) begin
            state_d   = S_OP;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            abort       = 1'b1;
          end
        end
        S_OP: begin
          addr_sh_d = {addr_sh_q[2:0], mdio_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            if ({addr_sh_q[0], mdio_s} == OP_READ) begin
              is_read_d = 1'b1;
              state_d   = S_PHYAD;
            end else if ({addr_sh_q[0], mdio_s} == OP_WRITE) begin
              is_read_d = 1'b0;
              state_d   = S_PHYAD;
            end else begin
              frame_err_d = 1'b1;
              abort       = 1'b1;
            end
          end
        end
        S_PHYAD: begin
          addr_sh_d = {addr_sh_q[2:0], mdio_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            if ({addr_sh_q, mdio_s} == PHY_ADDR) state_d = S_REGAD;
            else                                 abort   = 1'b1;
          end
        end
        S_REGAD: begin
          addr_sh_d = {addr_sh_q[2:0], mdio_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            state_d   = S_TA;
            wr_addr_d = {addr_sh_q, mdio_s};
            if (is_read_q) begin
              shift_d    = regs_q[{addr_sh_q, mdio_s}];
              rd_valid_d = 1'b1;
              rd_addr_d  = {addr_sh_q, mdio_s};
            end
          end
        end
        S_TA: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (!is_read_q && (mdio_s != (bit_cnt_q == 4'd0))) begin
            frame_err_d = 1'b1;
            abort       = 1'b1;
          end else if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (!is_read_q) shift_d = {shift_q[14:0], mdio_s};
          if (bit_cnt_q == 4'd15) begin
            frame_end = 1'b1;
            if (!is_read_q) begin
              smi_we     = 1'b1;
              smi_wa     = wr_addr_q;
              smi_wd     = {shift_q[14:0], mdio_s};
              wr_valid_d = 1'b1;
              wr_data_d  = {shift_q[14:0], mdio_s};
            end
          end
        end
        default: abort = 1'b1;
      endcase
    end else if (mdc_fall) begin
      if (state_q == S_TA && is_read_q && bit_cnt_q == 4'd1) begin
        mdio_oe_d  = 1'b1;
        mdio_out_d = 1'b0;
      end else if (state_q == S_DATA && is_read_q) begin
        mdio_out_d = shift_q[15];
        shift_d    = {shift_q[14:0], 1'b0};
      end else if (state_q == S_IDLE) begin
        mdio_oe_d = 1'b0;
      end
    end

    if (abort || frame_end) begin
      state_d   = S_IDLE;
      pre_cnt_d = '0;
      bit_cnt_d = '0;
`ifdef SMI_RESPONDER_PREAMBLE_SUPPRESS_EN
      sup_d     = frame_end;
`endif
    end

    // A same-address SMI commit takes precedence over the local write,
    // even when the SMI data is not stored because the register is read-only.
    if (loc_we && !(smi_we && smi_wa == loc_addr)) regs_d[loc_addr] = loc_wdata;
    if (smi_we && !RO_MASK[smi_wa])                regs_d[smi_wa]   = smi_wd;

    loc_rdata_d = regs_q[loc_addr];
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      is_read_q   <= 1'b0;
      addr_sh_q   <= '0;
      shift_q     <= '0;
      mdio_oe_q   <= 1'b0;
      mdio_out_q  <= 1'b0;
      regs_q      <= SMI_REG_RESET;
      loc_rdata_q <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      frame_err_q <= 1'b0;
`ifdef SMI_RESPONDER_PREAMBLE_SUPPRESS_EN
      sup_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      is_read_q   <= is_read_d;
      addr_sh_q   <= addr_sh_d;
      shift_q     <= shift_d;
      mdio_oe_q   <= mdio_oe_d;
      mdio_out_q  <= mdio_out_d;
      regs_q      <= regs_d;
      loc_rdata_q <= loc_rdata_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      frame_err_q <= frame_err_d;
`ifdef SMI_RESPONDER_PREAMBLE_SUPPRESS_EN
      sup_q       <= sup_d;
`endif
    end
  end

  assign mdio         = mdio_oe_q ? mdio_out_q : 1'bz;
  assign loc_rdata    = loc_rdata_q;
  assign smi_wr_valid = wr_valid_q;
  assign smi_wr_addr  = wr_addr_q;
  assign smi_wr_data  = wr_data_q;
  assign smi_rd_valid = rd_valid_q;
  assign smi_rd_addr  = rd_addr_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_smi_responder.sv
// tb_smi_responder: acts as the SMI master (mdc at 1.5625 MHz) and checks the
// responder against a scoreboard of expected write/read pulses and read data.
module tb_smi_responder;

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic        mdc = 1'b0;
  logic        loc_we = 1'b0;
  logic [4:0]  loc_addr = '0;
  logic [15:0] loc_wdata = '0;
  logic [15:0] loc_rdata;
  logic        smi_wr_valid, smi_rd_valid, frame_err;
  logic [4:0]  smi_wr_addr, smi_rd_addr;
  logic [15:0] smi_wr_data;

  wire  mdio;
  logic m_oe = 1'b0;
  logic m_out = 1'b1;
  assign mdio = m_oe ? m_out : 1'bz;
  pullup (mdio);

  smi_responder #(.PHY_ADDR(5'd1), .RO_MASK(32'h0000_0006), .PRE_LEN(32)) dut (
    .clk_100mhz   (clk_100mhz),
    .rst          (rst),
    .mdc          (mdc),
    .mdio         (mdio),
    .loc_we       (loc_we),
    .loc_addr     (loc_addr),
    .loc_wdata    (loc_wdata),
    .loc_rdata    (loc_rdata),
    .smi_wr_valid (smi_wr_valid),
    .smi_wr_addr  (smi_wr_addr),
    .smi_wr_data  (smi_wr_data),
    .smi_rd_valid (smi_rd_valid),
    .smi_rd_addr  (smi_rd_addr),
    .frame_err    (frame_err)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  logic        collide_en = 1'b0;
  logic [15:0] exp_rd_q[$];
  logic [20:0] exp_wr_q[$];
  logic [4:0]  exp_rdv_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pulse monitor: every write/read pulse must match the next scoreboard entry.
  always @(negedge clk_100mhz) begin
    if (!rst) begin
      if (smi_wr_valid) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else chk("wr_pulse", {11'd0, smi_wr_addr, smi_wr_data}, {11'd0, exp_wr_q.pop_front()});
      end
      if (smi_rd_valid) begin
        if (exp_rdv_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_pulse", {27'd0, smi_rd_addr}, {27'd0, exp_rdv_q.pop_front()});
      end
      if (frame_err) err_cnt++;
    end
  end

  task automatic mdc_cycle(input bit drv, input bit val, input bit hook, output bit smp);
    mdc = 1'b0; m_oe = drv; m_out = val;
    #320;
    smp = mdio;
    mdc = 1'b1;
    if (hook) begin
      // land loc_we on the cycle the responder acts on this rising edge
      @(posedge clk_100mhz); @(posedge clk_100mhz);
      #1 loc_we = 1'b1;
      @(posedge clk_100mhz);
      #1 loc_we = 1'b0;
    end
    #320;
  endtask

  // got = {TA1, TA2, data[15:0], one trailing bit} for read-format frames.
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input int abort_at,
                       output logic [18:0] got);
    bit s;
    logic [13:0] hdr;
    logic [17:0] wbits;
    hdr = {2'b01, op, phy, ra};
    wbits = {2'b10, wd};
    got = '0;
    for (int i = 0; i < pre; i++) mdc_cycle(1'b1, 1'b1, 1'b0, s);
    for (int i = 13; i >= 0; i--) mdc_cycle(1'b1, hdr[i], 1'b0, s);
    if (op == 2'b10) begin
      for (int i = 18; i >= 0; i--) begin
        if (i == abort_at) begin
          mdc = 1'b0; m_oe = 1'b0;
          #100;
          chk("rst_pre_drive", {31'd0, mdio}, 32'd0);
          rst = 1'b1;
          #5;
          chk("rst_release", {31'd0, mdio}, 32'd1);
          m_oe = 1'b1; m_out = 1'b1;
          return;
        end
        mdc_cycle(1'b0, 1'b0, 1'b0, s);
        got[i] = s;
      end
    end else begin
      for (int i = 17; i >= 0; i--) mdc_cycle(1'b1, wbits[i], collide_en && (i == 0), s);
    end
    m_oe = 1'b1; m_out = 1'b1;
  endtask

  task automatic do_read(input logic [4:0] ra, input logic [15:0] expd);
    logic [18:0] got;
    exp_rdv_q.push_back(ra);
    exp_rd_q.push_back(expd);
    frame(32, 2'b10, 5'd1, ra, 16'h0, -1, got);
    chk("rd_ta", {30'd0, got[18:17]}, 32'd2);
    chk("rd_data", {16'd0, got[16:1]}, {16'd0, exp_rd_q.pop_front()});
    chk("rd_release", {31'd0, got[0]}, 32'd1);
  endtask

  task automatic do_write(input logic [4:0] ra, input logic [15:0] d);
    logic [18:0] got;
    exp_wr_q.push_back({ra, d});
    frame(32, 2'b01, 5'd1, ra, d, -1, got);
  endtask

  task automatic read_loc(input string tag, input logic [4:0] a, input logic [15:0] expd);
    @(negedge clk_100mhz) loc_addr = a;
    @(negedge clk_100mhz);
    chk(tag, {16'd0, loc_rdata}, {16'd0, expd});
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [18:0] got;
    int e0;
    #52;
    chk("rst_loc_rdata", {16'd0, loc_rdata}, 32'd0);
    chk("rst_wr_valid", {31'd0, smi_wr_valid}, 32'd0);
    chk("rst_rd_valid", {31'd0, smi_rd_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_mdio", {31'd0, mdio}, 32'd1);
    m_oe = 1'b1;
    @(negedge clk_100mhz) rst = 1'b0;

    do_read(5'd2, 16'h0022);

    do_write(5'd0, 16'hA5A5);
    do_read(5'd0, 16'hA5A5);
    read_loc("loc_reg0", 5'd0, 16'hA5A5);

    do_write(5'd1, 16'hFFFF);
    read_loc("ro_reg1", 5'd1, 16'h7849);

    frame(32, 2'b10, 5'd3, 5'd2, 16'h0, -1, got);
    chk("phy3_nodrive", {13'd0, got}, 32'h7FFFF);

    e0 = err_cnt;
    frame(32, 2'b11, 5'd1, 5'd0, 16'h0000, -1, got);
    chk("op11_err", err_cnt - e0, 32'd1);

    frame(31, 2'b01, 5'd1, 5'd5, 16'h1111, -1, got);
    read_loc("pre31_reg5", 5'd5, 16'h0000);
    chk("pre31_noerr", err_cnt - e0, 32'd1);

    loc_addr = 5'd4; loc_wdata = 16'h0BAD; collide_en = 1'b1;
    do_write(5'd4, 16'h1234);
    collide_en = 1'b0;
    read_loc("collide_reg4", 5'd4, 16'h1234);

    loc_addr = 5'd6; loc_wdata = 16'h0BAD; collide_en = 1'b1;
    do_write(5'd7, 16'h5A5A);
    collide_en = 1'b0;
    read_loc("split_reg6", 5'd6, 16'h0BAD);
    read_loc("split_reg7", 5'd7, 16'h5A5A);

    exp_rdv_q.push_back(5'd2);
    frame(32, 2'b10, 5'd1, 5'd2, 16'h0, 9, got);
    #40;
    chk("rst2_loc_rdata", {16'd0, loc_rdata}, 32'd0);
    chk("rst2_wr_valid", {31'd0, smi_wr_valid}, 32'd0);
    @(negedge clk_100mhz) rst = 1'b0;
    read_loc("rst2_reg0", 5'd0, 16'h1140);
    read_loc("rst2_reg4", 5'd4, 16'h0000);
    do_read(5'd0, 16'h1140);

    #1000;
    chk("wr_q_empty", exp_wr_q.size(), 32'd0);
    chk("rdv_q_empty", exp_rdv_q.size(), 32'd0);
    chk("err_total", err_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/smi_responder.md
Name: smi_responder

Overview:
- Target (PHY-side) end of the IEEE 802.3 clause-22 SMI/MDIO management interface.
- Decodes MDC/MDIO frames from a station-management master and serves them from an internal 32 x 16-bit register file.
- Used to emulate a PHY management block in FPGA designs and as the loopback partner for the SMI master in system benches.
- Fabric logic updates status registers through a local port.

Parameters:
- PHY_ADDR, 5'd1: address this responder answers to; frames for other addresses are ignored.
- RO_MASK, 32'h0000_0006: bit n = 1 makes register n read-only from SMI (local port may still write it).
- PRE_LEN, 32: consecutive preamble ones required before ST.

Ports:
- clk_100mhz  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mdc  in  1  management clock from master (asynchronous, <= 2.5 MHz)
- mdio  inout  1  management data; driven only during read TA bit 2 and data; else 'z
- loc_we  in  1  local register write strobe
- loc_addr  in  5  local write/read address
- loc_wdata  in  16  local write data
- loc_rdata  out  16  register[loc_addr], registered, 1-cycle latency
- smi_wr_valid  out  1  1-cycle pulse: SMI write committed
- smi_wr_addr  out  5  register written
- smi_wr_data  out  16  data written
- smi_rd_valid  out  1  1-cycle pulse: SMI read address latched
- smi_rd_addr  out  5  register being read
- frame_err  out  1  1-cycle pulse: bad ST, OP or write TA

Behaviour:
- Reset values: all outputs 0, mdio released; state IDLE; registers = package SMI_REG_RESET.
  - Asserting rst mid-frame releases mdio immediately (output-enable flop cleared asynchronously).
- Input synchronisation:
  - mdc and mdio pass through 2-FF synchronisers; mdc is additionally registered once for edge detect.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Sampling uses synchronised mdio on rise; driving updates on fall.
  - Edge-to-action latency is 3 clk_100mhz cycles, well under the 320 ns half-period at 1.5625 MHz.
- All frame bits are MSB first.
- States (transitions on rise unless noted):
  - IDLE: count consecutive 1s (6-bit, saturating); any 0 resets the count. A 0 when count >= PRE_LEN is ST bit 0 -> ST.
  - ST: bit must be 1, else frame_err, -> IDLE.
  - OP: 2 bits. 10 = read, 01 = write. 00 or 11 -> frame_err, IDLE.
  - PHYAD: 5 bits. On the last bit, mismatch with PHY_ADDR -> IDLE silently (no err, never drives).
  - REGAD: 5 bits. On the last bit:
    - Read: snapshot register into the 16-bit shift register; pulse smi_rd_valid/smi_rd_addr.
  - TA: 2 bits.
    - Read: bit 1 stays 'z. On the fall after TA bit 1 is sampled, drive 0.
    - Write: sampled bits must be 1,0, else frame_err, IDLE.
  - DATA:
    - Read: on each subsequent fall drive shift[15], shift left; 16 bits.
    - Write: shift in 16 sampled bits.
    - After 16 bits -> IDLE. Read releases mdio on the fall following the data[0] rise.
- Write commit, on the rise sampling data bit 0:
  - If RO_MASK[addr] = 0: update register; pulse smi_wr_valid with addr/data.
  - If RO_MASK[addr] = 1: register unchanged, but smi_wr_valid still pulses (data reported, not stored).
- Collision: SMI commit and loc_we to the same address in the same cycle -> SMI wins, local write dropped. Different addresses both apply.
- Local writes after the read snapshot do not affect in-flight read data.
- Preamble counter restarts from 0 after every frame end or abort.
- IDLE, ST, OP, PHYAD, REGAD and write TA never drive mdio.

Optional Feature:
- Macro SMI_RESPONDER_PREAMBLE_SUPPRESS_EN.
- Defined: after a completed valid frame, the next frame may begin with 1 or more preamble ones (802.3 preamble suppression). The first frame after reset or after any abort still needs PRE_LEN ones.
- Undefined: PRE_LEN ones are required for every frame.

Decomposition:
- Package smi_pkg holds:
  - state enum smi_state_t
  - OP_READ = 2'b10, OP_WRITE = 2'b01, ST_CODE = 2'b01
  - SMI_REG_RESET, a 32 x 16-bit constant array: reg0 = 16'h1140, reg1 = 16'h7849, reg2 = 16'h0022, reg3 = 16'h1550, rest 0.
  - Shared with the SMI master.
- Sub-module smi_edge_sync: synchronisers plus rise/fall pulses for mdc, and synchronised mdio.

Test Plan:
- Read reg 2 at PHY_ADDR 1, 32-bit preamble at 1.5625 MHz -> master receives 16'h0022; smi_rd_valid pulses once with addr 2; mdio 'z outside TA2/data.
- Write reg 0 = 16'hA5A5, then read reg 0 -> smi_wr_valid with 0/A5A5; read returns A5A5; loc_rdata(addr 0) = A5A5.
- Write reg 1 = 16'hFFFF (RO) -> smi_wr_valid pulses; register keeps 16'h7849.
- Frame to PHY address 3 -> no drive, no pulses; OP = 11 -> frame_err. 31-bit preamble -> frame ignored.
- Assert rst during read data bit 8 -> mdio 'z within 1 cycle; regs back to SMI_REG_RESET; next full frame works.
- Simultaneous SMI commit and loc_we to reg 4 (16'h1234 vs 16'h0BAD) -> reg 4 = 16'h1234.
